// File: rtl/edge_event_arbiter_if.sv
// Event offer handshake between edge_event_arbiter and its consumer.
// The arbiter drives the master side; the consumer drives only evt_ready.
interface edge_event_arbiter_if #(
    parameter int CW = 2
);
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_ch;
    logic          evt_type;

    modport master (output evt_valid, output evt_ch, output evt_type, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_type, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with one pending slot per channel and a round-robin
// offer FSM; lost events are flagged in sticky overflow bits.
module edge_event_arbiter #(
    parameter int N_CH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [N_CH-1:0]       cfg_rise_en,
    input  logic [N_CH-1:0]       cfg_fall_en,
    input  logic                  ovf_clr,
    edge_event_arbiter_if.master  evt,
    output logic [N_CH-1:0]       pending,
    output logic [N_CH-1:0]       overflow
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] ptype_q, ptype_d;
    logic [N_CH-1:0] overflow_q, overflow_d;
    logic [CW-1:0]   last_grant_q, last_grant_d;
    logic            evt_valid_q, evt_valid_d;
    logic [CW-1:0]   evt_ch_q, evt_ch_d;
    logic            evt_type_q, evt_type_d;

    logic [N_CH-1:0] rise, fall, qedge, acc_vec, ovf_set;
    logic            accept;
    logic            found;
    logic [CW-1:0]   win;
    logic [CW:0]     sum;

    assign rise   = sig_in & ~prev_q & cfg_rise_en;
    assign fall   = ~sig_in & prev_q & cfg_fall_en;
    assign qedge  = rise | fall;
    assign accept = evt_valid_q && evt.evt_ready;

    // Pending slots: an edge arriving while its own slot is being accepted refills it.
    always_comb begin
        pending_d = pending_q;
        ptype_d   = ptype_q;
        ovf_set   = '0;
        acc_vec   = '0;
        if (accept) acc_vec[evt_ch_q] = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (qedge[i]) begin
                if (!pending_q[i] || acc_vec[i]) begin
                    pending_d[i] = 1'b1;
                    ptype_d[i]   = rise[i];
                end else begin
                    ovf_set[i] = 1'b1;
                end
            end else if (acc_vec[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        overflow_d = (ovf_clr ? '0 : overflow_q) | ovf_set;
    end

    // Round-robin search from last_grant+1 with explicit wrap (N_CH need not be a power of 2).
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned off = 1; off <= N_CH; off++) begin
            sum = {1'b0, last_grant_q} + (CW+1)'(off);
            if (sum >= (CW+1)'(N_CH)) sum = sum - (CW+1)'(N_CH);
            if (!found && pending_q[sum[CW-1:0]]) begin
                found = 1'b1;
                win   = sum[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        evt_valid_d  = evt_valid_q;
        evt_ch_d     = evt_ch_q;
        evt_type_d   = evt_type_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    evt_valid_d = 1'b1;
                    evt_ch_d    = win;
                    evt_type_d  = ptype_q[win];
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    evt_valid_d  = 1'b0;
                    last_grant_d = evt_ch_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        prev_q <= sig_in;
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            ptype_q      <= '0;
            overflow_q   <= '0;
            last_grant_q <= CW'(N_CH - 1);
            evt_valid_q  <= 1'b0;
            evt_ch_q     <= '0;
            evt_type_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ptype_q      <= ptype_d;
            overflow_q   <= overflow_d;
            last_grant_q <= last_grant_d;
            evt_valid_q  <= evt_valid_d;
            evt_ch_q     <= evt_ch_d;
            evt_type_q   <= evt_type_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_ch    = evt_ch_q;
    assign evt.evt_type  = evt_type_q;
    assign pending       = pending_q;
    assign overflow      = overflow_q;
endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 The block SHALL have one parameter, N_CH: default 4; number of monitored input channels, legal range 2..8.
REQ-002 The block SHALL have port clk: input, 1 bit; rising-edge clock for all state.
REQ-003 The block SHALL have port reset: input, 1 bit; reset reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port sig_in: input, N_CH bits; monitored levels, already synchronous to clk.
REQ-005 The block SHALL have port cfg_rise_en: input, N_CH bits; per-channel rising-edge enable.
REQ-006 The block SHALL have port cfg_fall_en: input, N_CH bits; per-channel falling-edge enable.
REQ-007 The block SHALL have port evt_ready: input, 1 bit; consumer accepts the offered event.
REQ-008 The block SHALL have port ovf_clr: input, 1 bit; one-cycle pulse that clears all overflow bits.
REQ-009 The block SHALL have port evt_valid: output, 1 bit; event offered.
REQ-010 The block SHALL have port evt_ch: output, CW = max(1, ceil(log2 N_CH)) bits; channel index of the offered event.
REQ-011 The block SHALL have port evt_type: output, 1 bit; 1 = rising, 0 = falling.
REQ-012 The block SHALL have port pending: output, N_CH bits; per-channel event-waiting flags.
REQ-013 The block SHALL have port overflow: output, N_CH bits; sticky lost-event flags.

Function
REQ-014 Each channel SHALL hold prev[i], a copy of sig_in[i] registered every cycle.
- Rise: sig_in[i]=1 and prev[i]=0, qualified by cfg_rise_en[i].
- Fall: sig_in[i]=0 and prev[i]=1, qualified by cfg_fall_en[i].
REQ-015 A qualified edge on a channel with pending[i]=0 SHALL set pending[i] and latch its type into ptype[i] at that clock edge.
REQ-016 A qualified edge on a channel with pending[i]=1 that is not being accepted that cycle SHALL set overflow[i]; the existing pending event and ptype[i] stay unchanged and the new event is dropped.
REQ-017 When a qualified edge arrives in the same cycle that channel's event is accepted, the new event SHALL become pending and SHALL NOT set overflow.
REQ-018 The controller SHALL be an FSM with states IDLE and OFFER.
- IDLE, any pending bit set: load the round-robin winner into evt_ch and its ptype into evt_type, set evt_valid, go to OFFER.
- IDLE, no pending bit set: stay in IDLE with evt_valid=0.
REQ-019 Round-robin search SHALL start at (last_grant+1) mod N_CH and increase with wrap-around; last_grant resets to N_CH-1, so channel 0 has priority first.
REQ-020 In OFFER, evt_valid, evt_ch and evt_type SHALL stay stable until evt_ready=1.
REQ-021 On evt_valid=1 and evt_ready=1, the block SHALL clear pending[evt_ch], set last_grant=evt_ch, deassert evt_valid and return to IDLE on the next edge.
REQ-022 Latency: an edge first sampled at clock edge k SHALL set pending at edge k; if IDLE and the channel wins, evt_valid SHALL be high after edge k+1.
REQ-023 Maximum throughput SHALL be one accepted event per 2 cycles.
REQ-024 evt_ready while evt_valid=0 SHALL be ignored.
REQ-025 Changes on cfg_rise_en or cfg_fall_en SHALL affect only future detection; existing pending events are kept.
REQ-026 ovf_clr SHALL clear all overflow bits; if a set and a clear occur in the same cycle, the set SHALL win for that bit.

Reset
REQ-027 While reset=1, the block SHALL drive state to IDLE, evt_valid=0, evt_ch=0, evt_type=0, pending=0, overflow=0, last_grant=N_CH-1 and ptype=0.
REQ-028 While reset=1, prev SHALL load sig_in, so no spurious edge is detected on the first cycle after reset.
REQ-029 Reset asserted during OFFER SHALL discard the offered event; evt_valid SHALL be 0 after the next edge.

Verification
REQ-030 The bench SHALL cover: sig_in[2] 0->1 with rise enabled and evt_ready=1 -> evt_valid after 2 edges, evt_ch=2, evt_type=1, pending[2] cleared after acceptance.
REQ-031 The bench SHALL cover: rising edges on channels 0,1,3 in the same cycle with evt_ready held 1 -> grants in order 0,1,3, one per 2 cycles.
REQ-032 The bench SHALL cover: evt_ready=0 for 5 cycles with ch1 pending, then a second ch1 edge -> outputs stable, overflow[1]=1, after ready only the first event's type is delivered.
REQ-033 The bench SHALL cover: ch0 fall with cfg_fall_en[0]=0 -> no pending bit and no event; the same fall with the enable set -> evt_type=0.
REQ-034 The bench SHALL cover: ovf_clr in the same cycle as a new overflow on ch2 -> overflow[2] stays 1 and the other bits clear.
REQ-035 The bench SHALL cover: sig_in all 1 during reset, then reset released -> no event; reset asserted during OFFER -> evt_valid=0 after the next edge.
